seg_scan_ctrl: RTL and testbench

CPU-mapped, parametrised multiplexed 7-segment display controller for up to 8 digits, plus an 8-bit static LED port.
- Successor of the 4-digit scanner: digit count, scan rate and register width are generalised.
- Adds per-digit blink, 16-level PWM brightness, global display enable and a frame-complete pulse.
- Sits on the CPU peripheral bus next to the clock/timer peripherals and drives the board's segment and digit-select pins.

---
 rtl/seg_scan_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Brief    : CPU-mapped multiplexed 7-segment scanner for up to 8 digits with
//            per-digit blink, 16-level PWM brightness and a static LED port.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int ADDRWIDTH    = 4,
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 1563,
    parameter int DIV_WIDTH    = 16,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr,
    input  logic [ADDRWIDTH-1:0] waddr,
    input  logic [31:0]          wdata,
    input  logic                 rd,
    input  logic [ADDRWIDTH-1:0] raddr,
    output logic [31:0]          rdata,
    output logic [DIGITS-1:0]    scan_cs,
    output logic [7:0]           scan_out,
    output logic [7:0]           static_out,
    output logic                 frame_tick
);

    localparam int c_idx_w   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int c_blink_w = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DIV_WIDTH-1:0] c_div_last   = DIV_WIDTH'(SCAN_DIV - 1);
    localparam logic [c_idx_w-1:0]   c_idx_last   = c_idx_w'(DIGITS - 1);
    localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_FRAMES - 1);

    localparam logic [ADDRWIDTH-1:0] c_addr_ctrl   = ADDRWIDTH'(32'h0);
    localparam logic [ADDRWIDTH-1:0] c_addr_data0  = ADDRWIDTH'(32'h4);
    localparam logic [ADDRWIDTH-1:0] c_addr_static = ADDRWIDTH'(32'h8);
    localparam logic [ADDRWIDTH-1:0] c_addr_data1  = ADDRWIDTH'(32'hC);

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic                 r_enable;
    logic [7:0]           r_mask;
    logic [3:0]           r_bright;
    logic [31:0]          r_data0;
    logic [31:0]          r_data1;
    logic [7:0]           r_static;
    logic [31:0]          r_rdata;
    logic [31:0]          w_rd_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_enable <= 1'b0;
            r_mask   <= 8'h00;
            r_bright <= 4'h0;
            r_data0  <= 32'h0;
            r_data1  <= 32'h0;
            r_static <= 8'h00;
        end else if (wr) begin
            case (waddr)
                c_addr_ctrl: begin
                    r_enable <= wdata[0];
                    r_mask   <= wdata[15:8];
                    r_bright <= wdata[19:16];
                end
                c_addr_data0:  r_data0  <= wdata;
                c_addr_static: r_static <= wdata[7:0];
                c_addr_data1:  r_data1  <= wdata;
                default: ;
            endcase
        end
    end

    // Read mux looks at the pre-write register value, so a same-cycle
    // write/read of one address returns the old contents.
    always_comb begin
        w_rd_val = 32'h0;
        case (raddr)
            c_addr_ctrl:   w_rd_val = {12'h000, r_bright, r_mask, 7'h00, r_enable};
            c_addr_data0:  w_rd_val = r_data0;
            c_addr_static: w_rd_val = {24'h000000, r_static};
            c_addr_data1:  w_rd_val = r_data1;
            default:       w_rd_val = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= 32'h0;
        end else begin
            r_rdata <= rd ? w_rd_val : 32'h0;
        end
    end

    // ------------------------------------------------------------------
    // Scan timebase: prescaler -> 16 sub-phases -> digit index
    // ------------------------------------------------------------------
    logic [DIV_WIDTH-1:0] r_presc;
    logic [3:0]           r_sub;
    logic [c_idx_w-1:0]   r_idx;
    logic [c_blink_w-1:0] r_blink_cnt;
    logic                 r_blink;
    logic                 r_frame_tick;
    logic                 w_tick;
    logic                 w_slot_end;
    logic                 w_frame_end;

    assign w_tick      = (r_presc == c_div_last);
    assign w_slot_end  = w_tick && (r_sub == 4'hF);
    assign w_frame_end = w_slot_end && (r_idx == c_idx_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sub <= 4'h0;
            r_idx <= '0;
        end else if (w_tick) begin
            r_sub <= r_sub + 4'h1;
            if (r_sub == 4'hF) begin
                r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
            end
        end
    end

    // Blink state keeps running with the display disabled so that re-enabling
    // does not restart the blink cadence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_tick <= 1'b0;
            r_blink_cnt  <= '0;
            r_blink      <= 1'b0;
        end else begin
            r_frame_tick <= w_frame_end;
            if (w_frame_end) begin
                if (r_blink_cnt == c_blink_last) begin
                    r_blink_cnt <= '0;
                    r_blink     <= ~r_blink;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Digit selection and segment decode
    // ------------------------------------------------------------------
    logic [2:0]        w_idx3;
    logic [63:0]       w_data64;
    logic              w_on;
    logic              w_dp;
    logic              w_dash;
    logic [3:0]        w_hex;
    logic [6:0]        w_hex_seg;
    logic [6:0]        w_segs;
    logic              w_sel;
    logic [DIGITS-1:0] w_cs_next;
    logic [7:0]        w_out_next;

    assign w_idx3   = 3'(r_idx);
    assign w_data64 = {r_data1, r_data0};
    assign w_on     = w_data64[{w_idx3, 3'd7}];
    assign w_dp     = w_data64[{w_idx3, 3'd6}];
    assign w_dash   = w_data64[{w_idx3, 3'd5}];
    assign w_hex    = w_data64[{w_idx3, 3'd0} +: 4];

    // Segment order {a,b,c,d,e,f,g}
    always_comb begin
        w_hex_seg = 7'b0000000;
        case (w_hex)
            4'h0: w_hex_seg = 7'b1111110;
            4'h1: w_hex_seg = 7'b0110000;
            4'h2: w_hex_seg = 7'b1101101;
            4'h3: w_hex_seg = 7'b1111001;
            4'h4: w_hex_seg = 7'b0110011;
            4'h5: w_hex_seg = 7'b1011011;
            4'h6: w_hex_seg = 7'b1011111;
            4'h7: w_hex_seg = 7'b1110000;
            4'h8: w_hex_seg = 7'b1111111;
            4'h9: w_hex_seg = 7'b1111011;
            4'hA: w_hex_seg = 7'b1110111;
            4'hB: w_hex_seg = 7'b0011111;
            4'hC: w_hex_seg = 7'b1001110;
            4'hD: w_hex_seg = 7'b0111101;
            4'hE: w_hex_seg = 7'b1001111;
            4'hF: w_hex_seg = 7'b1000111;
            default: w_hex_seg = 7'b0000000;
        endcase
    end

    always_comb begin
        w_segs = 7'b0000000;
        if (w_on) begin
            w_segs = w_dash ? 7'b0000001 : w_hex_seg;
        end
    end

    // PWM: the digit is lit on sub-phases 0..B of its 16-tick slot.
    assign w_sel = r_enable && (r_sub <= r_bright) && !(r_mask[w_idx3] && r_blink);

    always_comb begin
        w_cs_next = '1;
        for (int i = 0; i < DIGITS; i++) begin
            w_cs_next[i] = !(w_sel && (int'(r_idx) == i));
        end
    end

    assign w_out_next = w_sel ? {w_segs, w_dp} : 8'h00;

    logic [DIGITS-1:0] r_cs;
    logic [7:0]        r_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cs  <= '1;
            r_out <= 8'h00;
        end else if (w_tick) begin
            r_cs  <= w_cs_next;
            r_out <= w_out_next;
        end
    end

    assign rdata      = r_rdata;
    assign scan_cs    = r_cs;
    assign scan_out   = r_out;
    assign static_out = r_static;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Brief    : Self-checking bench for seg_scan_ctrl (8-digit and 3-digit builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int c_digits     = 8;
    localparam int c_div        = 3;
    localparam int c_bf         = 2;
    localparam int c_frame_clks = c_digits * 16 * c_div;
    localparam int c_d3_frame   = 3 * 16 * 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic        rd;
    logic [3:0]  raddr;

    logic [31:0] rdata;
    logic [7:0]  scan_cs;
    logic [7:0]  scan_out;
    logic [7:0]  static_out;
    logic        frame_tick;

    logic [31:0] rdata3;
    logic [2:0]  scan_cs3;
    logic [7:0]  scan_out3;
    logic [7:0]  static_out3;
    logic        frame_tick3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .ADDRWIDTH(4), .DIGITS(c_digits), .SCAN_DIV(c_div), .DIV_WIDTH(4), .BLINK_FRAMES(c_bf)
    ) dut (
        .clk(clk), .rst(rst), .wr(wr), .waddr(waddr), .wdata(wdata),
        .rd(rd), .raddr(raddr), .rdata(rdata), .scan_cs(scan_cs),
        .scan_out(scan_out), .static_out(static_out), .frame_tick(frame_tick)
    );

    seg_scan_ctrl #(
        .ADDRWIDTH(4), .DIGITS(3), .SCAN_DIV(2), .DIV_WIDTH(4), .BLINK_FRAMES(2)
    ) dut3 (
        .clk(clk), .rst(rst), .wr(wr), .waddr(waddr), .wdata(wdata),
        .rd(rd), .raddr(raddr), .rdata(rdata3), .scan_cs(scan_cs3),
        .scan_out(scan_out3), .static_out(static_out3), .frame_tick(frame_tick3)
    );

    // ------------------------------------------------------------------
    // Reference model: position in the scan is derived from the absolute
    // clock count since reset release.
    // ------------------------------------------------------------------
    logic [31:0] m_ctrl, m_data0, m_data1;
    int          m_cyc;
    logic        m_tick;
    logic        m_ft;
    logic [15:0] exp_q[$];
    logic [31:0] rd_q[$];

    int          m_t, m_d, m_p, m_fr;
    logic        m_blink, m_sel;
    logic [63:0] m_dat;
    logic [7:0]  m_byte, m_cs, m_out;
    logic [6:0]  m_seg;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;  default: return 7'b1000111;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc   = 0;
            m_tick  = 1'b0;
            m_ft    = 1'b0;
            m_ctrl  = 32'h0;
            m_data0 = 32'h0;
            m_data1 = 32'h0;
            exp_q.delete();
        end else begin
            m_cyc  = m_cyc + 1;
            m_tick = (m_cyc % c_div) == 0;
            m_ft   = 1'b0;
            if (m_tick) begin
                m_t     = m_cyc / c_div - 1;
                m_d     = (m_t / 16) % c_digits;
                m_p     = m_t % 16;
                m_fr    = m_t / (16 * c_digits);
                m_blink = ((m_fr / c_bf) % 2) == 1;
                m_dat   = {m_data1, m_data0};
                m_byte  = m_dat[8*m_d +: 8];
                m_sel   = m_ctrl[0] && (m_p <= int'(m_ctrl[19:16])) && !(m_ctrl[8+m_d] && m_blink);
                m_seg   = !m_byte[7] ? 7'b0000000 : (m_byte[5] ? 7'b0000001 : hex7(m_byte[3:0]));
                m_cs    = m_sel ? ~(8'h01 << m_d) : 8'hFF;
                m_out   = m_sel ? {m_seg, m_byte[6]} : 8'h00;
                exp_q.push_back({m_cs, m_out});
                m_ft    = (m_t % (16 * c_digits)) == (16 * c_digits - 1);
            end
            if (wr) begin
                case (waddr)
                    4'h0: m_ctrl  = wdata;
                    4'h4: m_data0 = wdata;
                    4'hC: m_data1 = wdata;
                    default: ;
                endcase
            end
        end
    end

    logic [15:0] sb_exp;

    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if (frame_tick !== m_ft) begin
                n_errors++;
                $display("FAIL frame_tick @%0t: got %b expected %b", $time, frame_tick, m_ft);
            end
            if (m_tick) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL scoreboard_empty @%0t", $time);
                end else begin
                    sb_exp = exp_q.pop_front();
                    if ({scan_cs, scan_out} !== sb_exp) begin
                        n_errors++;
                        $display("FAIL scan @%0t: got cs=%h out=%h expected cs=%h out=%h",
                                 $time, scan_cs, scan_out, sb_exp[15:8], sb_exp[7:0]);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus driver
    // ------------------------------------------------------------------
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        wr = 1'b1; waddr = a; wdata = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset;
        rst = 1'b1; wr = 1'b0; rd = 1'b0; waddr = 4'h0; raddr = 4'h0; wdata = 32'h0;
        repeat (3) @(negedge clk);
        n_checks++; if (rdata !== 32'h0)     begin n_errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        n_checks++; if (scan_cs !== 8'hFF)   begin n_errors++; $display("FAIL reset_cs: got %h expected ff", scan_cs); end
        n_checks++; if (scan_out !== 8'h00)  begin n_errors++; $display("FAIL reset_out: got %h expected 0", scan_out); end
        n_checks++; if (static_out !== 8'h0) begin n_errors++; $display("FAIL reset_static: got %h expected 0", static_out); end
        n_checks++; if (frame_tick !== 1'b0) begin n_errors++; $display("FAIL reset_ft: got %b expected 0", frame_tick); end
        n_checks++; if (scan_cs3 !== 3'b111) begin n_errors++; $display("FAIL reset_cs3: got %b expected 111", scan_cs3); end
        rst = 1'b0;
    endtask

    task automatic test_scan_hex;
        int cnt[4];
        logic [7:0] seg[4];
        int ticks, guard;
        for (int i = 0; i < 4; i++) begin cnt[i] = 0; seg[i] = 8'hXX; end
        bus_write(4'h4, 32'h8F8A8180);
        bus_write(4'h0, 32'h000F0001);
        ticks = 0; guard = 0;
        while (ticks < 128 && guard < 128 * c_div + 8) begin
            @(negedge clk); guard++;
            if (m_tick) begin
                ticks++;
                for (int i = 0; i < 4; i++) begin
                    if (scan_cs == ~(8'h01 << i)) begin cnt[i]++; seg[i] = scan_out; end
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (cnt[i] !== 16) begin n_errors++; $display("FAIL hex_slot_len%0d: got %0d ticks expected 16", i, cnt[i]); end
        end
        n_checks++; if (seg[0] !== 8'hFC) begin n_errors++; $display("FAIL hex_d0: got %h expected fc", seg[0]); end
        n_checks++; if (seg[1] !== 8'h60) begin n_errors++; $display("FAIL hex_d1: got %h expected 60", seg[1]); end
        n_checks++; if (seg[2] !== 8'hEE) begin n_errors++; $display("FAIL hex_d2: got %h expected ee", seg[2]); end
        n_checks++; if (seg[3] !== 8'h8E) begin n_errors++; $display("FAIL hex_d3: got %h expected 8e", seg[3]); end
    endtask

    task automatic test_regs;
        logic [31:0] e;
        bus_write(4'h8, 32'h0000005A);
        n_checks++; if (static_out !== 8'h5A) begin n_errors++; $display("FAIL static_out: got %h expected 5a", static_out); end
        @(negedge clk); rd = 1'b1; raddr = 4'h0; rd_q.push_back(32'h000F0001);
        @(negedge clk); e = rd_q.pop_front();
        n_checks++; if (rdata !== e) begin n_errors++; $display("FAIL read_ctrl: got %h expected %h", rdata, e); end
        raddr = 4'h8; rd_q.push_back(32'h0000005A);
        @(negedge clk); e = rd_q.pop_front();
        n_checks++; if (rdata !== e) begin n_errors++; $display("FAIL read_static: got %h expected %h", rdata, e); end
        raddr = 4'h2; rd_q.push_back(32'h0);
        @(negedge clk); e = rd_q.pop_front();
        n_checks++; if (rdata !== e) begin n_errors++; $display("FAIL read_unmapped: got %h expected %h", rdata, e); end
        rd = 1'b0; raddr = 4'h0; rd_q.push_back(32'h0);
        @(negedge clk); e = rd_q.pop_front();
        n_checks++; if (rdata !== e) begin n_errors++; $display("FAIL read_idle: got %h expected %h", rdata, e); end
        bus_write(4'hC, 32'h11223344);
        wr = 1'b1; waddr = 4'hC; wdata = 32'h55667788;
        rd = 1'b1; raddr = 4'hC; rd_q.push_back(32'h11223344);
        @(negedge clk); wr = 1'b0; e = rd_q.pop_front();
        n_checks++; if (rdata !== e) begin n_errors++; $display("FAIL read_old_on_write: got %h expected %h", rdata, e); end
        rd_q.push_back(32'h55667788);
        @(negedge clk); e = rd_q.pop_front(); rd = 1'b0;
        n_checks++; if (rdata !== e) begin n_errors++; $display("FAIL read_new_data1: got %h expected %h", rdata, e); end
        n_checks++; if (rdata3 !== 32'h55667788) begin n_errors++; $display("FAIL read_data1_dig3: got %h expected 55667788", rdata3); end
    endtask

    task automatic test_brightness;
        int act, ticks, guard;
        for (int b = 0; b < 2; b++) begin
            bus_write(4'h0, (b == 0) ? 32'h00030001 : 32'h00000001);
            act = 0; ticks = 0; guard = 0;
            while (ticks < 128 && guard < 128 * c_div + 8) begin
                @(negedge clk); guard++;
                if (m_tick) begin
                    ticks++;
                    if (scan_cs !== 8'hFF) act++;
                end
            end
            n_checks++;
            if (act !== ((b == 0) ? 32 : 8)) begin
                n_errors++;
                $display("FAIL bright_duty_B%0d: got %0d lit ticks expected %0d", (b == 0) ? 3 : 0, act, (b == 0) ? 32 : 8);
            end
        end
    endtask

    task automatic test_blink;
        int c[4];
        int fd, cyc, period, guard;
        logic ok;
        bus_write(4'h0, 32'h000F0101);
        guard = 0;
        while (frame_tick !== 1'b1 && guard < 2 * c_frame_clks) begin @(negedge clk); guard++; end
        n_checks++;
        if (frame_tick !== 1'b1) begin n_errors++; $display("FAIL blink_wait_frame: got no frame_tick expected one"); end
        fd = 0; period = 0;
        for (int f = 0; f < 4; f++) begin
            c[f] = 0; cyc = 0;
            do begin
                @(negedge clk); cyc++;
                if (m_tick && scan_cs == 8'hFE) c[f]++;
                if (m_tick && scan_cs == 8'hFD) fd++;
            end while (frame_tick !== 1'b1 && cyc < 2 * c_frame_clks);
            if (f == 0) period = cyc;
        end
        n_checks++;
        if (period !== c_frame_clks) begin n_errors++; $display("FAIL frame_period: got %0d expected %0d", period, c_frame_clks); end
        n_checks++;
        if (fd !== 64) begin n_errors++; $display("FAIL blink_other_digit: got %0d ticks expected 64", fd); end
        ok = ((c[0] == c[1] && c[2] == c[3] && c[0] != c[2]) || (c[1] == c[2] && c[3] == c[0] && c[1] != c[3]))
             && (c[0] + c[1] + c[2] + c[3] == 32) && (c[0] == 0 || c[0] == 16) && (c[1] == 0 || c[1] == 16);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL blink_pattern: got %0d/%0d/%0d/%0d expected two 16-tick frames then two blank", c[0], c[1], c[2], c[3]);
        end
    endtask

    task automatic test_encoding;
        logic [7:0] s0, s1, s2;
        int ticks, guard;
        s0 = 8'hXX; s1 = 8'hXX; s2 = 8'hXX;
        bus_write(4'h4, 32'h000045A0);
        bus_write(4'h0, 32'h000F0001);
        ticks = 0; guard = 0;
        while (ticks < 128 && guard < 128 * c_div + 8) begin
            @(negedge clk); guard++;
            if (m_tick) begin
                ticks++;
                if (scan_cs == 8'hFE) s0 = scan_out;
                if (scan_cs == 8'hFD) s1 = scan_out;
                if (scan_cs == 8'hFB) s2 = scan_out;
            end
        end
        n_checks++; if (s0 !== 8'h02) begin n_errors++; $display("FAIL enc_dash: got %h expected 02", s0); end
        n_checks++; if (s1 !== 8'h01) begin n_errors++; $display("FAIL enc_off_dp: got %h expected 01", s1); end
        n_checks++; if (s2 !== 8'h00) begin n_errors++; $display("FAIL enc_off: got %h expected 00", s2); end
    endtask

    task automatic test_digits3;
        int n6, n5, n3, nother, cyc, guard;
        guard = 0;
        while (frame_tick3 !== 1'b1 && guard < 4 * c_d3_frame) begin @(negedge clk); guard++; end
        n6 = 0; n5 = 0; n3 = 0; nother = 0; cyc = 0;
        do begin
            @(negedge clk); cyc++;
            case (scan_cs3)
                3'b110:  n6++;
                3'b101:  n5++;
                3'b011:  n3++;
                default: nother++;
            endcase
        end while (frame_tick3 !== 1'b1 && cyc < 4 * c_d3_frame);
        n_checks++; if (cyc !== c_d3_frame) begin n_errors++; $display("FAIL d3_frame_period: got %0d expected %0d", cyc, c_d3_frame); end
        n_checks++; if (n6 !== 32) begin n_errors++; $display("FAIL d3_digit0: got %0d clks expected 32", n6); end
        n_checks++; if (n5 !== 32) begin n_errors++; $display("FAIL d3_digit1: got %0d clks expected 32", n5); end
        n_checks++; if (n3 !== 32) begin n_errors++; $display("FAIL d3_digit2: got %0d clks expected 32", n3); end
        n_checks++; if (nother !== 0) begin n_errors++; $display("FAIL d3_extra: got %0d clks expected 0", nother); end
        bus_write(4'h0, 32'h0000FF01);
        @(negedge clk); rd = 1'b1; raddr = 4'h0;
        @(negedge clk); rd = 1'b0;
        n_checks++; if (rdata3 !== 32'h0000FF01) begin n_errors++; $display("FAIL d3_mask_store: got %h expected 0000ff01", rdata3); end
    endtask

    task automatic test_reset_midframe;
        int guard;
        logic [7:0] first;
        bus_write(4'h0, 32'h000F0001);
        repeat (100) @(negedge clk);
        rd = 1'b1; raddr = 4'h0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (scan_cs !== 8'hFF)   begin n_errors++; $display("FAIL mid_reset_cs: got %h expected ff", scan_cs); end
        n_checks++; if (scan_out !== 8'h00)  begin n_errors++; $display("FAIL mid_reset_out: got %h expected 00", scan_out); end
        n_checks++; if (rdata !== 32'h0)     begin n_errors++; $display("FAIL mid_reset_rdata: got %h expected 0", rdata); end
        n_checks++; if (static_out !== 8'h0) begin n_errors++; $display("FAIL mid_reset_static: got %h expected 0", static_out); end
        rd = 1'b0;
        @(negedge clk); rst = 1'b0;
        bus_write(4'h0, 32'h000F0001);
        guard = 0; first = 8'hFF;
        while (first == 8'hFF && guard < 64) begin
            @(negedge clk); guard++;
            if (m_tick) first = scan_cs;
        end
        n_checks++; if (first !== 8'hFE) begin n_errors++; $display("FAIL restart_digit0: got %h expected fe", first); end
        repeat (200) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_scan_hex();
        test_regs();
        test_brightness();
        test_blink();
        test_encoding();
        test_digits3();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
